// File: rtl/spi_flash_resp_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_resp_if
//  Description : SPI pad signals and byte-wide backing-memory port of the
//                SPI flash responder, bundled with responder/host views.
//  Revision    : 1.0  initial release
// ============================================================================
interface spi_flash_resp_if #(
   parameter int AW = 16
);
   logic          spi_clk_i;
   logic          spi_mosi_i;
   logic          spi_cs_n_i;
   logic          spi_miso_o;
   logic          spi_miso_oe;
   logic [AW-1:0] mem_addr;
   logic          mem_re;
   logic          mem_we;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   // Responder side: sees the SPI pads as inputs, owns the memory strobes.
   modport slave (
      input  spi_clk_i, spi_mosi_i, spi_cs_n_i, mem_rdata,
      output spi_miso_o, spi_miso_oe, mem_addr, mem_re, mem_we, mem_wdata
   );

   // Host/environment side: drives the SPI pads and returns memory data.
   modport master (
      output spi_clk_i, spi_mosi_i, spi_cs_n_i, mem_rdata,
      input  spi_miso_o, spi_miso_oe, mem_addr, mem_re, mem_we, mem_wdata
   );
endinterface
`default_nettype wire

// File: rtl/spi_flash_resp.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_resp
//  Description : SPI (mode 0) serial-flash responder. Decodes READ (03),
//                PAGE PROGRAM (02), JEDEC ID (9F), READ STATUS (05), WREN (06)
//                and WRDI (04) against a byte-wide backing memory. All SPI
//                pads are oversampled by the system clock.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_flash_resp #(
   parameter int          AW       = 16,
   parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_flash_resp_if.slave  bus
);
   localparam logic [AW-1:0] ONE       = AW'(1);
   localparam logic [AW-1:0] PAGE_MASK = AW'(8'hFF);

   typedef enum logic [2:0] {
      ST_CMD, ST_ADDR, ST_READ, ST_PROG, ST_ID, ST_STAT, ST_IGNORE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    cs_sync_q, sck_sync_q, mosi_sync_q;
   logic          sck_prev_q, sck_prev_d;
   logic [1:0]    warm_q, warm_d;
   logic          armed_q, armed_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    rx_q, rx_d;
   logic [7:0]    tx_q, tx_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [1:0]    addr_cnt_q, addr_cnt_d;
   logic          is_read_q, is_read_d;
   logic [1:0]    id_idx_q, id_idx_d;
   logic          wel_q, wel_d;
   logic          wrote_q, wrote_d;
   logic          rd_pend_q, rd_pend_d;
   logic          miso_q, miso_d;
   logic          mem_re_q, mem_re_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]    mem_wdata_q, mem_wdata_d;

   logic          w_cs, w_sck, w_mosi, w_rise, w_fall, w_active;
   logic          w_byte_done, w_tx_state;
   logic [7:0]    w_rx_next, w_tx_src;
   logic [AW+7:0] w_addr_shift;

   assign w_cs         = cs_sync_q[1];
   assign w_sck        = sck_sync_q[1];
   assign w_mosi       = mosi_sync_q[1];
   assign w_rise       = w_sck & ~sck_prev_q;
   assign w_fall       = ~w_sck & sck_prev_q;
   // Bus is only honoured once a clean CS-high has been seen after reset;
   // a raised CS always overrides any SCK edge in the same cycle.
   assign w_active     = armed_q & ~w_cs;
   assign w_rx_next    = {rx_q[6:0], w_mosi};
   assign w_byte_done  = w_active & w_rise & (bit_cnt_q == 3'd7);
   assign w_addr_shift = {addr_q, w_rx_next};
   // Memory data arrives the cycle after mem_re; use it directly if a fall
   // needs it before it could be parked in the TX register.
   assign w_tx_src     = rd_pend_q ? bus.mem_rdata : tx_q;
   assign w_tx_state   = (state_q == ST_READ) || (state_q == ST_ID) ||
                         (state_q == ST_STAT);

   assign bus.spi_miso_oe = w_active & w_tx_state;
   assign bus.spi_miso_o  = miso_q & bus.spi_miso_oe;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_re      = mem_re_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_wdata   = mem_wdata_q;

   // Two-stage synchronizers for the raw pads; idle bus is CS high, SCK low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_sync_q   <= 2'b11;
         sck_sync_q  <= 2'b00;
         mosi_sync_q <= 2'b00;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], bus.spi_cs_n_i};
         sck_sync_q  <= {sck_sync_q[0], bus.spi_clk_i};
         mosi_sync_q <= {mosi_sync_q[0], bus.spi_mosi_i};
      end
   end

   // Protocol state and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CMD;
         sck_prev_q  <= 1'b0;
         warm_q      <= 2'd0;
         armed_q     <= 1'b0;
         bit_cnt_q   <= 3'd0;
         rx_q        <= 8'h00;
         tx_q        <= 8'h00;
         addr_q      <= '0;
         addr_cnt_q  <= 2'd0;
         is_read_q   <= 1'b0;
         id_idx_q    <= 2'd0;
         wel_q       <= 1'b0;
         wrote_q     <= 1'b0;
         rd_pend_q   <= 1'b0;
         miso_q      <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 8'h00;
      end else begin
         state_q     <= state_d;
         sck_prev_q  <= sck_prev_d;
         warm_q      <= warm_d;
         armed_q     <= armed_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         addr_q      <= addr_d;
         addr_cnt_q  <= addr_cnt_d;
         is_read_q   <= is_read_d;
         id_idx_q    <= id_idx_d;
         wel_q       <= wel_d;
         wrote_q     <= wrote_d;
         rd_pend_q   <= rd_pend_d;
         miso_q      <= miso_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   // Next-state: bit shifting, command decode and memory strobes.
   always_comb begin
      state_d     = state_q;
      sck_prev_d  = w_sck;
      warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
      armed_d     = armed_q | (w_cs & (warm_q == 2'd2));
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = rd_pend_q ? bus.mem_rdata : tx_q;
      addr_d      = addr_q;
      addr_cnt_d  = addr_cnt_q;
      is_read_d   = is_read_q;
      id_idx_d    = id_idx_q;
      wel_d       = wel_q;
      wrote_d     = wrote_q;
      rd_pend_d   = mem_re_q;
      miso_d      = miso_q;
      mem_re_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      if (!w_active) begin
         state_d    = ST_CMD;
         bit_cnt_d  = 3'd0;
         rx_d       = 8'h00;
         miso_d     = 1'b0;
         addr_cnt_d = 2'd0;
         id_idx_d   = 2'd0;
         // A program burst that stored data consumes the write enable.
         if (wrote_q) begin
            wel_d   = 1'b0;
            wrote_d = 1'b0;
         end
      end else begin
         if (w_rise) begin
            rx_d      = w_rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
         end
         if (w_fall && w_tx_state) begin
            miso_d = w_tx_src[7];
            tx_d   = {w_tx_src[6:0], 1'b0};
         end
         if (w_byte_done) begin
            case (state_q)
               ST_CMD: begin
                  case (w_rx_next)
                     8'h03: begin state_d = ST_ADDR; is_read_d = 1'b1; addr_cnt_d = 2'd0; end
                     8'h02: begin state_d = ST_ADDR; is_read_d = 1'b0; addr_cnt_d = 2'd0; end
                     8'h9F: begin state_d = ST_ID; tx_d = JEDEC_ID[23:16]; id_idx_d = 2'd1; end
                     8'h05: begin state_d = ST_STAT; tx_d = {6'b0, wel_q, 1'b0}; end
                     8'h06: begin state_d = ST_IGNORE; wel_d = 1'b1; end
                     8'h04: begin state_d = ST_IGNORE; wel_d = 1'b0; end
                     default: state_d = ST_IGNORE;
                  endcase
               end
               ST_ADDR: begin
                  addr_d     = w_addr_shift[AW-1:0];
                  addr_cnt_d = addr_cnt_q + 2'd1;
                  if (addr_cnt_q == 2'd2) begin
                     if (is_read_q) begin
                        state_d    = ST_READ;
                        mem_re_d   = 1'b1;
                        mem_addr_d = w_addr_shift[AW-1:0];
                        addr_d     = w_addr_shift[AW-1:0] + ONE;
                     end else begin
                        state_d = ST_PROG;
                     end
                  end
               end
               ST_READ: begin
                  mem_re_d   = 1'b1;
                  mem_addr_d = addr_q;
                  addr_d     = addr_q + ONE;
               end
               ST_PROG: begin
                  if (wel_q) begin
                     mem_we_d    = 1'b1;
                     mem_addr_d  = addr_q;
                     mem_wdata_d = w_rx_next;
                     wrote_d     = 1'b1;
                     addr_d      = (addr_q & ~PAGE_MASK) | ((addr_q + ONE) & PAGE_MASK);
                  end
               end
               ST_ID: begin
                  case (id_idx_q)
                     2'd1:    tx_d = JEDEC_ID[15:8];
                     2'd2:    tx_d = JEDEC_ID[7:0];
                     default: tx_d = 8'h00;
                  endcase
                  if (id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
               end
               ST_STAT: tx_d = {6'b0, wel_q, 1'b0};
               default: ;
            endcase
         end
      end
   end
endmodule
`default_nettype wire
